// File: rtl/slot_request_arbiter_if.sv
// slot_request_arbiter_if
//   Bundles the slot-side request handshake and the VFU-side request
//   handshake of the slot request arbiter.
//
//   Signals (N_IN slots, DATA_W payload bits, IDX_W source index bits):
//     io_in_valid   [N_IN]         per-slot request valid
//     io_in_ready   [N_IN]         per-slot accept (at most one bit high)
//     io_in_bits    [N_IN*DATA_W]  slot i payload at [i*DATA_W +: DATA_W]
//     io_out_valid                 request to VFU valid
//     io_out_ready                 VFU accepts
//     io_out_bits   [DATA_W]       selected payload
//     io_out_source [IDX_W]        slot index that issued io_out_bits
//
//   Modports:
//     master - the environment (slots + VFU) driving requests and ready
//     slave  - the arbiter itself
interface slot_request_arbiter_if #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 206,
  parameter int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
);

  logic [N_IN-1:0]        io_in_valid;
  logic [N_IN-1:0]        io_in_ready;
  logic [N_IN*DATA_W-1:0] io_in_bits;
  logic                   io_out_valid;
  logic                   io_out_ready;
  logic [DATA_W-1:0]      io_out_bits;
  logic [IDX_W-1:0]       io_out_source;

  modport master (
    output io_in_valid,
    output io_in_bits,
    output io_out_ready,
    input  io_in_ready,
    input  io_out_valid,
    input  io_out_bits,
    input  io_out_source
  );

  modport slave (
    input  io_in_valid,
    input  io_in_bits,
    input  io_out_ready,
    output io_in_ready,
    output io_out_valid,
    output io_out_bits,
    output io_out_source
  );

endinterface

// File: rtl/slot_request_arbiter.sv
// slot_request_arbiter
//   N-input round-robin arbiter between a lane's execution slots and a
//   shared vector functional unit. The winning slot's payload is forwarded
//   together with its slot index.
//
//   Ports:
//     clock  - sole clock, all state on the rising edge
//     reset  - synchronous, active-low
//     bus    - slot_request_arbiter_if.slave (slot and VFU handshakes)
//
//   Build option:
//     SLOT_ARB_SKID_EN defined   - two-entry skid buffer on the output,
//                                  1-cycle latency, no combinational
//                                  io_out_ready -> io_in_ready path.
//     SLOT_ARB_SKID_EN undefined - zero-latency bypass with a lock that
//                                  keeps the stalled winner stable.
//
//   N_IN = 1 degenerates to a wire-through (bypass) or a plain two-entry
//   buffer (skid); the pointer and lock are held constant.
module slot_request_arbiter #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 206,
  parameter int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input logic                   clock,
  input logic                   reset,
  slot_request_arbiter_if.slave bus
);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  rrIdx;
  logic              rrFound;
  logic [IDX_W-1:0]  winIdx;
  logic [N_IN-1:0]   winOneHot;
  logic [DATA_W-1:0] winBits;
  logic              anyValid;
  logic [N_IN-1:0]   inReady;
  logic              inFire;

  assign anyValid  = |bus.io_in_valid;
  assign winOneHot = N_IN'(1) << winIdx;
  assign winBits   = bus.io_in_bits[int'(winIdx)*DATA_W +: DATA_W];
  assign inFire    = |(bus.io_in_valid & inReady);

  assign bus.io_in_ready = inReady;

  // First valid slot scanning from ptr upward with wrap-around.
  always_comb begin
    int j;
    j       = 0;
    rrIdx   = '0;
    rrFound = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_IN) j = j - N_IN;
      if (!rrFound && bus.io_in_valid[j]) begin
        rrFound = 1'b1;
        rrIdx   = IDX_W'(j);
      end
    end
  end

  // Pointer moves just past whichever slot was accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (N_IN > 1 && inFire) begin
      ptr_d = (winIdx == IDX_W'(N_IN - 1)) ? '0 : winIdx + IDX_W'(1);
    end
  end

`ifdef SLOT_ARB_SKID_EN

  // Two-entry buffer: entry 0 is always the head presented to the VFU.
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] e0Bits_q, e0Bits_d, e1Bits_q, e1Bits_d;
  logic [IDX_W-1:0]  e0Src_q, e0Src_d, e1Src_q, e1Src_d;
  logic              push;
  logic              pop;
  logic              outValid;

  assign winIdx = rrIdx;

  // Ready depends only on buffer occupancy; reset also forces it low so
  // nothing is accepted into a buffer that is being cleared.
  always_comb begin
    inReady = '0;
    if (reset && anyValid && count_q != 2'd2) inReady = winOneHot;
  end

  assign push     = inFire;
  assign outValid = reset && (count_q != 2'd0);
  assign pop      = outValid && bus.io_out_ready;

  assign bus.io_out_valid  = outValid;
  assign bus.io_out_bits   = e0Bits_q;
  assign bus.io_out_source = e0Src_q;

  // Buffer update. A push with a pop only happens at count 1 (push is
  // blocked when full), so the new entry simply replaces the head.
  always_comb begin
    count_d  = count_q;
    e0Bits_d = e0Bits_q;
    e0Src_d  = e0Src_q;
    e1Bits_d = e1Bits_q;
    e1Src_d  = e1Src_q;
    case ({push, pop})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          e0Bits_d = winBits;
          e0Src_d  = winIdx;
        end else begin
          e1Bits_d = winBits;
          e1Src_d  = winIdx;
        end
      end
      2'b01: begin
        count_d  = count_q - 2'd1;
        e0Bits_d = e1Bits_q;
        e0Src_d  = e1Src_q;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          e0Bits_d = winBits;
          e0Src_d  = winIdx;
        end else begin
          e0Bits_d = e1Bits_q;
          e0Src_d  = e1Src_q;
          e1Bits_d = winBits;
          e1Src_d  = winIdx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= 2'd0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed when count != 0.
  always_ff @(posedge clock) begin
    e0Bits_q <= e0Bits_d;
    e0Src_q  <= e0Src_d;
    e1Bits_q <= e1Bits_d;
    e1Src_q  <= e1Src_d;
  end

`else

  // Lock keeps a stalled winner on the bus even if a higher-priority slot
  // raises valid while the VFU is back-pressuring.
  logic             lockVld_q, lockVld_d;
  logic [IDX_W-1:0] lockIdx_q, lockIdx_d;

  assign winIdx = (N_IN > 1 && lockVld_q) ? lockIdx_q : rrIdx;

  // N_IN = 1 is a pure wire-through, so ready does not wait for valid.
  always_comb begin
    inReady = '0;
    if (N_IN == 1) inReady = {N_IN{bus.io_out_ready}};
    else if (anyValid && bus.io_out_ready) inReady = winOneHot;
  end

  assign bus.io_out_valid  = anyValid;
  assign bus.io_out_bits   = winBits;
  assign bus.io_out_source = winIdx;

  always_comb begin
    lockVld_d = lockVld_q;
    lockIdx_d = lockIdx_q;
    if (N_IN > 1 && anyValid) begin
      if (!bus.io_out_ready) begin
        lockVld_d = 1'b1;
        lockIdx_d = winIdx;
      end else begin
        lockVld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q     <= '0;
      lockVld_q <= 1'b0;
      lockIdx_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lockVld_q <= lockVld_d;
      lockIdx_q <= lockIdx_d;
    end
  end

`endif

endmodule

// File: tb/tb_slot_request_arbiter.sv
// tb_slot_request_arbiter
//   Directed bench for slot_request_arbiter: a 4-slot instance and a
//   1-slot instance sharing clock and reset. Covers whichever build
//   (bypass or SLOT_ARB_SKID_EN) is compiled.
module tb_slot_request_arbiter;

  localparam int DW = 16;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  slot_request_arbiter_if #(.N_IN(4), .DATA_W(DW)) ifc ();
  slot_request_arbiter_if #(.N_IN(1), .DATA_W(DW)) ifc1 ();

  slot_request_arbiter #(.N_IN(4), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  slot_request_arbiter #(.N_IN(1), .DATA_W(DW)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] payloadOf(input int i);
    return 16'hA500 + 16'(i * 17);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic outReady);
    ifc.io_in_valid  = valid;
    ifc.io_out_ready = outReady;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkWinner(input string tag, input int src,
                             input logic [3:0] rdy);
    checkOutput({tag, "_valid"}, 32'(ifc.io_out_valid), 32'd1);
    checkOutput({tag, "_src"}, 32'(ifc.io_out_source), 32'(src));
    checkOutput({tag, "_bits"}, 32'(ifc.io_out_bits), 32'(payloadOf(src)));
    checkOutput({tag, "_ready"}, 32'(ifc.io_in_ready), 32'(rdy));
  endtask

  initial begin
    logic [15:0] b1;
    logic        v1;
    logic        r1;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4; i++) ifc.io_in_bits[i*DW +: DW] = payloadOf(i);
    ifc1.io_in_valid  = 1'b0;
    ifc1.io_in_bits   = '0;
    ifc1.io_out_ready = 1'b0;
    reset = 1'b0;
    applyStimulus(4'hF, 1'b1);

    // Reset held for three edges with every slot requesting.
    for (int c = 0; c < 3; c++) begin
`ifdef SLOT_ARB_SKID_EN
      checkOutput($sformatf("rst_outvalid_%0d", c), 32'(ifc.io_out_valid), 32'd0);
      checkOutput($sformatf("rst_inready_%0d", c), 32'(ifc.io_in_ready), 32'd0);
`endif
      tick();
    end
    reset = 1'b1;

`ifdef SLOT_ARB_SKID_EN
    // Empty after reset: nothing presented, slot 0 accepted first.
    applyStimulus(4'hF, 1'b1);
    checkOutput("post_rst_outvalid", 32'(ifc.io_out_valid), 32'd0);
    checkOutput("post_rst_ready", 32'(ifc.io_in_ready), 32'h1);
    tick();

    // Continuous traffic: one request out per cycle, count stays at 1.
    for (int k = 1; k < 8; k++) begin
      applyStimulus(4'hF, 1'b1);
      checkWinner($sformatf("fair_%0d", k), (k - 1) % 4, 4'(1 << (k % 4)));
      tick();
    end
    applyStimulus(4'h0, 1'b1);
    checkWinner("fair_8", 3, 4'h0);
    tick();
    applyStimulus(4'h0, 1'b1);
    checkOutput("drained_outvalid", 32'(ifc.io_out_valid), 32'd0);

    // Fill the buffer while stalled, then drain in FIFO order.
    applyStimulus(4'b0011, 1'b0);
    checkOutput("full_a_outvalid", 32'(ifc.io_out_valid), 32'd0);
    checkOutput("full_a_ready", 32'(ifc.io_in_ready), 32'h1);
    tick();
    applyStimulus(4'b0011, 1'b0);
    checkWinner("full_b", 0, 4'b0010);
    tick();
    applyStimulus(4'b0011, 1'b0);
    checkWinner("full_c", 0, 4'b0000);
    tick();
    applyStimulus(4'b0011, 1'b0);
    checkWinner("full_d", 0, 4'b0000);
    applyStimulus(4'b0000, 1'b1);
    checkWinner("drain_0", 0, 4'b0000);
    tick();
    checkWinner("drain_1", 1, 4'b0000);
    tick();
    checkOutput("drain_empty", 32'(ifc.io_out_valid), 32'd0);

    // Reset mid-operation discards a buffered request.
    applyStimulus(4'b0001, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("midrst_before", 32'(ifc.io_out_valid), 32'd1);
    reset = 1'b0;
    applyStimulus(4'b0001, 1'b0);
    checkOutput("midrst_outvalid", 32'(ifc.io_out_valid), 32'd0);
    checkOutput("midrst_inready", 32'(ifc.io_in_ready), 32'd0);
    tick();
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    checkOutput("midrst_after", 32'(ifc.io_out_valid), 32'd0);

    // Single-slot instance: one-cycle latency, source always 0.
    ifc1.io_in_valid  = 1'b1;
    ifc1.io_in_bits   = 16'h5A5A;
    ifc1.io_out_ready = 1'b1;
    #1;
    checkOutput("n1_ready", 32'(ifc1.io_in_ready), 32'd1);
    checkOutput("n1_outvalid0", 32'(ifc1.io_out_valid), 32'd0);
    tick();
    ifc1.io_in_valid = 1'b0;
    #1;
    checkOutput("n1_outvalid1", 32'(ifc1.io_out_valid), 32'd1);
    checkOutput("n1_bits", 32'(ifc1.io_out_bits), 32'h5A5A);
    checkOutput("n1_src", 32'(ifc1.io_out_source), 32'd0);
    tick();
    checkOutput("n1_outvalid2", 32'(ifc1.io_out_valid), 32'd0);
`else
    // Bypass: slot 0 wins immediately after reset.
    applyStimulus(4'hF, 1'b1);
    checkWinner("post_rst", 0, 4'h1);

    // Fairness: eight accepts rotate through all slots.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'hF, 1'b1);
      checkWinner($sformatf("fair_%0d", k), k % 4, 4'(1 << (k % 4)));
      tick();
    end

    // Stall on slot 2 with ptr at 0; slot 1 arrives but must not steal.
    applyStimulus(4'b0100, 1'b0);
    checkWinner("lock_0", 2, 4'b0000);
    tick();
    applyStimulus(4'b0110, 1'b0);
    checkWinner("lock_1", 2, 4'b0000);
    tick();
    applyStimulus(4'b0110, 1'b0);
    checkWinner("lock_2", 2, 4'b0000);
    tick();
    applyStimulus(4'b0110, 1'b1);
    checkWinner("lock_fire", 2, 4'b0100);
    tick();
    applyStimulus(4'b1010, 1'b1);
    checkWinner("after_lock_3", 3, 4'b1000);
    tick();
    applyStimulus(4'b0010, 1'b1);
    checkWinner("after_lock_1", 1, 4'b0010);
    tick();

    // Reset while locked on slot 3 clears both lock and pointer.
    applyStimulus(4'b1000, 1'b0);
    checkWinner("midrst_lock", 3, 4'b0000);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    applyStimulus(4'b1001, 1'b1);
    checkWinner("midrst_after", 0, 4'b0001);
    tick();

    // Single-slot instance is a wire-through.
    for (int n = 0; n < 10; n++) begin
      v1 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      b1 = 16'($urandom);
      ifc1.io_in_valid  = v1;
      ifc1.io_out_ready = r1;
      ifc1.io_in_bits   = b1;
      #1;
      checkOutput($sformatf("n1_valid_%0d", n), 32'(ifc1.io_out_valid), 32'(v1));
      checkOutput($sformatf("n1_ready_%0d", n), 32'(ifc1.io_in_ready), 32'(r1));
      checkOutput($sformatf("n1_bits_%0d", n), 32'(ifc1.io_out_bits), 32'(b1));
      checkOutput($sformatf("n1_src_%0d", n), 32'(ifc1.io_out_source), 32'd0);
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slot_request_arbiter.md
# slot_request_arbiter

Parametrised N-input round-robin arbiter for packed slot-to-VFU requests, placed between a lane's execution slots and a shared vector functional unit. It generalises the single-input pass-through arbiter: multiple slots compete fairly, the selected source index travels with the request, and output payload is held stable while stalled. An optional two-entry skid buffer registers the output and cuts the combinational ready path from VFU back to slots.

## Interface
Parameters:
- `N_IN`, 4: number of requesting slots, 1..8; `N_IN=1` degenerates to a pass-through.
- `DATA_W`, 206: packed request width (src0..3, opcode, masks, control fields, tag).
- `IDX_W`, `$clog2(N_IN)` (min 1): width of `io_out_source`.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clock`.
- `io_in_valid`  in  N_IN  per-slot request valid.
- `io_in_ready`  out  N_IN  per-slot accept; at most one bit high per cycle.
- `io_in_bits`  in  N_IN*DATA_W  slot i payload at bits [i*DATA_W +: DATA_W].
- `io_out_valid`  out  1  request to VFU valid.
- `io_out_ready`  in  1  VFU accepts.
- `io_out_bits`  out  DATA_W  selected payload.
- `io_out_source`  out  IDX_W  index of the slot that issued `io_out_bits`.

## Operation
- Round-robin pointer `ptr` (IDX_W bits): priority order is ptr, ptr+1, …, N_IN-1, 0, …, ptr-1. Winner = first valid slot in that order.
- Input fire (`io_in_valid[i] && io_in_ready[i]`): `ptr` <= i+1, wrapping N_IN-1 -> 0. No fire: `ptr` unchanged.
- Lock (bypass build): register `lock_vld`, `lock_idx`. If `io_out_valid && !io_out_ready`, set `lock_vld`=1, `lock_idx`=winner; while locked, winner is forced to `lock_idx`, regardless of higher-priority arrivals. Cleared on the cycle the output fires.
- Upstream must hold valid/bits stable until accepted; the arbiter does not check this.
- `io_in_ready[i]` is high only for the winner, and only when downstream can accept (see Timing).
- `N_IN=1`: no pointer or lock; `io_out_source`=0; behaviour identical to the wire-through arbiter.

## Timing
- Reset (`reset`=0 at an edge): `ptr`=0, `lock_vld`=0, skid count=0. Outputs after reset: `io_out_valid`=0, `io_in_ready`=0 in the skid build while reset is asserted. In the bypass build they follow the combinational rules. `io_out_bits` and `io_out_source` are don't-care while `io_out_valid`=0.
- Bypass build: zero latency. `io_out_valid` = any `io_in_valid`. `io_in_ready[winner]` = `io_out_ready`, giving a combinational ready path.
- Skid build: 1-cycle latency from input fire to `io_out_valid`.
  - Buffer depth 2, count 0..2. `io_in_ready[winner]` = (count != 2), with no dependence on `io_out_ready`.
  - `io_out_valid` = (count != 0). Output is the head entry, held stable until popped.
  - Push and pop in the same cycle: count unchanged, FIFO order kept.
  - Full (count=2): all `io_in_ready` low; `ptr` frozen.
  - Empty with a push: `io_out_valid` rises the next cycle.
  - Lock is unnecessary in this build and not instantiated.
- Reset asserted mid-operation discards buffered and locked requests. Producers must reissue them.

## Configuration
- `SLOT_ARB_SKID_EN` defined: the two-entry skid buffer is compiled in. Latency is 1 cycle and there is no combinational `io_out_ready`->`io_in_ready` path.
- Not defined: bypass build with zero latency, combinational ready, and the lock registers. Throughput is one request per cycle in both builds.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with all `io_in_valid`=1 -> `ptr`=0. In the skid build, `io_out_valid`=0 throughout.
- Fairness: N_IN=4, all valid, `io_out_ready`=1 for 8 accepts -> `io_out_source` sequence 0,1,2,3,0,1,2,3, one-hot `io_in_ready`.
- Stall/lock (bypass): slot 2 wins, `io_out_ready`=0 for 3 cycles, slot 1 raises valid after `ptr` passes it -> `io_out_source` stays 2 and `io_out_bits` is unchanged until fire. Next winner is 3 if it is valid, else 1.
- Skid full (skid build): `io_out_ready`=0, slots 0 and 1 valid -> two pushes, count=2, then all `io_in_ready`=0. Release `io_out_ready` -> outputs source 0 then 1 on consecutive cycles.
- Simultaneous push/pop (skid build): count=1, continuous traffic with `io_out_ready`=1 -> count stays 1 and one request fires per cycle with no bubbles.
- Degenerate N_IN=1: random valid/ready -> `io_out_*` equals `io_in_*` (bypass build), `io_out_source`=0.
